// File: rtl/pipe_control_unit_if.sv
// Control-unit bus: ID-stage instruction fields and EX zero flag in, stage controls,
// hazard enables and forwarding selects out. Parameterised to match the control unit.
interface pipe_control_unit_if #(
    parameter int OPW = 5,
    parameter int RAW = 4
);
    logic [OPW-1:0] id_opcode;
    logic [RAW-1:0] id_rs1;
    logic [RAW-1:0] id_rs2;
    logic [RAW-1:0] id_rd;
    logic           ex_zero;

    logic [OPW-1:0] ex_opcode;
    logic           ex_bsel;
    logic           mem_rd;
    logic           mem_wd;
    logic           wb_reg_write;
    logic [1:0]     wb_reg_sel;
    logic [RAW-1:0] wb_rd;
    logic           pc_select;
    logic           en_pc;
    logic           en_ifid;
    logic           flush_ifid;
    logic [1:0]     fwd_a;
    logic [1:0]     fwd_b;

    // Datapath side: presents the ID instruction, consumes the controls.
    modport master (
        output id_opcode, id_rs1, id_rs2, id_rd, ex_zero,
        input  ex_opcode, ex_bsel, mem_rd, mem_wd, wb_reg_write, wb_reg_sel, wb_rd,
        input  pc_select, en_pc, en_ifid, flush_ifid, fwd_a, fwd_b
    );

    // Control-unit side.
    modport slave (
        input  id_opcode, id_rs1, id_rs2, id_rd, ex_zero,
        output ex_opcode, ex_bsel, mem_rd, mem_wd, wb_reg_write, wb_reg_sel, wb_rd,
        output pc_select, en_pc, en_ifid, flush_ifid, fwd_a, fwd_b
    );
endinterface

// File: rtl/pipe_control_unit.sv
// Pipelined control unit: decodes ID, carries controls through ID/EX, EX/MEM, MEM/WB,
// resolves branches in EX and handles hazards. Define FWD_EN to enable operand forwarding.
module pipe_control_unit #(
    parameter int OPW = 5,
    parameter int RAW = 4
) (
    input logic                clk,
    input logic                rst,
    pipe_control_unit_if.slave bus
);

    typedef struct packed {
        logic [OPW-1:0] opcode;
        logic           bsel;
        logic           mem_rd;
        logic           mem_wd;
        logic           write;
        logic [1:0]     sel;
        logic [RAW-1:0] rd;
    } ex_ctl_t;

    typedef struct packed {
        logic           mem_rd;
        logic           mem_wd;
        logic           write;
        logic [1:0]     sel;
        logic [RAW-1:0] rd;
    } mem_ctl_t;

    typedef struct packed {
        logic           write;
        logic [1:0]     sel;
        logic [RAW-1:0] rd;
    } wb_ctl_t;

    localparam logic [OPW-1:0] OP_ADD  = OPW'(5'd0);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(5'd1);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(5'd2);
    localparam logic [OPW-1:0] OP_SUBI = OPW'(5'd3);
    localparam logic [OPW-1:0] OP_MLT  = OPW'(5'd4);
    localparam logic [OPW-1:0] OP_MLTI = OPW'(5'd5);
    localparam logic [OPW-1:0] OP_AND  = OPW'(5'd6);
    localparam logic [OPW-1:0] OP_OR   = OPW'(5'd7);
    localparam logic [OPW-1:0] OP_ANDI = OPW'(5'd8);
    localparam logic [OPW-1:0] OP_ORI  = OPW'(5'd9);
    localparam logic [OPW-1:0] OP_SLR  = OPW'(5'd10);
    localparam logic [OPW-1:0] OP_SLL  = OPW'(5'd11);
    localparam logic [OPW-1:0] OP_LDR  = OPW'(5'd12);
    localparam logic [OPW-1:0] OP_STR  = OPW'(5'd13);
    localparam logic [OPW-1:0] OP_BNE  = OPW'(5'd14);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(5'd15);
    localparam logic [OPW-1:0] OP_J    = OPW'(5'd16);
    localparam logic [OPW-1:0] OP_CMP  = OPW'(5'd17);
    localparam logic [OPW-1:0] OP_NOP  = {OPW{1'b1}};

    localparam logic [1:0] SEL_ALU_R = 2'd0;
    localparam logic [1:0] SEL_ALU_I = 2'd1;
    localparam logic [1:0] SEL_MEM   = 2'd2;

    localparam ex_ctl_t EX_BUBBLE = '{
        opcode: OP_NOP, bsel: 1'b0, mem_rd: 1'b0, mem_wd: 1'b0,
        write: 1'b0, sel: SEL_ALU_R, rd: {RAW{1'b0}}
    };
    localparam mem_ctl_t MEM_BUBBLE = '{
        mem_rd: 1'b0, mem_wd: 1'b0, write: 1'b0, sel: SEL_ALU_R, rd: {RAW{1'b0}}
    };
    localparam wb_ctl_t WB_BUBBLE = '{write: 1'b0, sel: SEL_ALU_R, rd: {RAW{1'b0}}};

    // A source depends on a stage only if it is read, the stage writes, and the target is not r0.
    function automatic logic src_hit(input logic           used,
                                     input logic           write,
                                     input logic [RAW-1:0] rd,
                                     input logic [RAW-1:0] src);
        return used & write & (rd != {RAW{1'b0}}) & (rd == src);
    endfunction

`ifdef FWD_EN
    // Select is chosen in ID for where the producer will sit once the consumer reaches EX.
    function automatic logic [1:0] fwd_pick(input logic           used,
                                            input logic [RAW-1:0] src,
                                            input ex_ctl_t        ex,
                                            input mem_ctl_t       mem);
        logic [1:0] pick;
        if (src_hit(used, ex.write, ex.rd, src) & ~ex.mem_rd) begin
            pick = 2'd1;
        end else if (src_hit(used, mem.write, mem.rd, src)) begin
            pick = 2'd2;
        end else begin
            pick = 2'd0;
        end
        return pick;
    endfunction
`endif

    ex_ctl_t        ex_q, ex_d;
    mem_ctl_t       mem_q, mem_d;
    wb_ctl_t        wb_q, wb_d;
    ex_ctl_t        dec_s;
    logic           use_rs1_s;
    logic           use_rs2_s;
    logic           branch_s;
    logic           stall_req_s;
    logic           stall_s;
    logic [1:0]     fwd_a_s;
    logic [1:0]     fwd_b_s;

    // Decode the ID opcode into its control bundle and source usage.
    always_comb begin
        dec_s        = EX_BUBBLE;
        dec_s.opcode = bus.id_opcode;
        use_rs1_s    = 1'b0;
        use_rs2_s    = 1'b0;
        case (bus.id_opcode)
            OP_ADD, OP_SUB, OP_MLT, OP_AND, OP_OR, OP_CMP: begin
                dec_s.write = 1'b1;
                dec_s.sel   = SEL_ALU_R;
                use_rs1_s   = 1'b1;
                use_rs2_s   = 1'b1;
            end
            OP_ADDI, OP_SUBI, OP_MLTI, OP_ANDI, OP_ORI, OP_SLR, OP_SLL: begin
                dec_s.bsel  = 1'b1;
                dec_s.write = 1'b1;
                dec_s.sel   = SEL_ALU_I;
                use_rs1_s   = 1'b1;
            end
            OP_LDR: begin
                dec_s.bsel   = 1'b1;
                dec_s.mem_rd = 1'b1;
                dec_s.write  = 1'b1;
                dec_s.sel    = SEL_MEM;
                use_rs1_s    = 1'b1;
            end
            OP_STR: begin
                dec_s.bsel   = 1'b1;
                dec_s.mem_wd = 1'b1;
                use_rs1_s    = 1'b1;
                use_rs2_s    = 1'b1;
            end
            OP_BNE, OP_BEQ: begin
                use_rs1_s = 1'b1;
                use_rs2_s = 1'b1;
            end
            default: begin
                dec_s.write = 1'b0;
            end
        endcase
        // Non-writers carry rd=0 so they can never look like a hazard source.
        if (dec_s.write) begin
            dec_s.rd = bus.id_rd;
        end else begin
            dec_s.rd = {RAW{1'b0}};
        end
    end

    // Branch resolution on the instruction currently in EX.
    always_comb begin
        branch_s = 1'b0;
        case (ex_q.opcode)
            OP_BEQ:  branch_s = bus.ex_zero;
            OP_BNE:  branch_s = ~bus.ex_zero;
            OP_J:    branch_s = 1'b1;
            default: branch_s = 1'b0;
        endcase
    end

    // Hazard detection and forwarding selects.
    always_comb begin
`ifdef FWD_EN
        stall_req_s = ex_q.mem_rd &
                      (src_hit(use_rs1_s, ex_q.write, ex_q.rd, bus.id_rs1) |
                       src_hit(use_rs2_s, ex_q.write, ex_q.rd, bus.id_rs2));
        fwd_a_s     = fwd_pick(use_rs1_s, bus.id_rs1, ex_q, mem_q);
        fwd_b_s     = fwd_pick(use_rs2_s, bus.id_rs2, ex_q, mem_q);
`else
        stall_req_s = src_hit(use_rs1_s, ex_q.write,  ex_q.rd,  bus.id_rs1) |
                      src_hit(use_rs2_s, ex_q.write,  ex_q.rd,  bus.id_rs2) |
                      src_hit(use_rs1_s, mem_q.write, mem_q.rd, bus.id_rs1) |
                      src_hit(use_rs2_s, mem_q.write, mem_q.rd, bus.id_rs2) |
                      src_hit(use_rs1_s, wb_q.write,  wb_q.rd,  bus.id_rs1) |
                      src_hit(use_rs2_s, wb_q.write,  wb_q.rd,  bus.id_rs2);
        fwd_a_s     = 2'd0;
        fwd_b_s     = 2'd0;
`endif
        // A taken branch flushes ID anyway, so its stall request is moot.
        stall_s = stall_req_s & ~branch_s;
    end

    // Next-state for the three stage registers.
    always_comb begin
        if (branch_s | stall_s) begin
            ex_d = EX_BUBBLE;
        end else begin
            ex_d = dec_s;
        end
        mem_d = '{mem_rd: ex_q.mem_rd, mem_wd: ex_q.mem_wd, write: ex_q.write,
                  sel: ex_q.sel, rd: ex_q.rd};
        wb_d  = '{write: mem_q.write, sel: mem_q.sel, rd: mem_q.rd};
    end

    // Stage registers; reset drops every in-flight bundle at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= EX_BUBBLE;
            mem_q <= MEM_BUBBLE;
            wb_q  <= WB_BUBBLE;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign bus.ex_opcode    = ex_q.opcode;
    assign bus.ex_bsel      = ex_q.bsel;
    assign bus.mem_rd       = mem_q.mem_rd;
    assign bus.mem_wd       = mem_q.mem_wd;
    assign bus.wb_reg_write = wb_q.write;
    assign bus.wb_reg_sel   = wb_q.sel;
    assign bus.wb_rd        = wb_q.rd;
    assign bus.pc_select    = branch_s;
    assign bus.flush_ifid   = branch_s;
    assign bus.en_pc        = ~stall_s;
    assign bus.en_ifid      = ~stall_s;
    assign bus.fwd_a        = fwd_a_s;
    assign bus.fwd_b        = fwd_b_s;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Bench for pipe_control_unit: directed scenarios then random instruction streams,
// checked against an instruction-level pipeline model. Honours FWD_EN like the design.
module tb_pipe_control_unit;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_ADDI = 5'd2;
    localparam logic [4:0] OP_LDR  = 5'd12;
    localparam logic [4:0] OP_STR  = 5'd13;
    localparam logic [4:0] OP_BNE  = 5'd14;
    localparam logic [4:0] OP_BEQ  = 5'd15;
    localparam logic [4:0] OP_J    = 5'd16;
    localparam logic [4:0] OP_NOP  = 5'd31;

`ifdef FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_control_unit_if #(.OPW(5), .RAW(4)) bus ();
    pipe_control_unit #(.OPW(5), .RAW(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [4:0] op;
        bit         wr;
        logic [3:0] rd;
    } rec_t;

    localparam rec_t BUB = '{op: 5'd31, wr: 1'b0, rd: 4'd0};

    rec_t pipe [3];     // 0 = in EX, 1 = in MEM, 2 = in WB
    int   checks = 0;
    int   passed = 0;
    int   failed = 0;
    bit   comb_ok = 1'b0;
    bit   m_stall = 1'b0;
    bit   m_branch = 1'b0;
    logic       last_pcs, last_flush, last_en;
    logic [1:0] last_fa, last_fb;

    logic [4:0] bop [5] = '{OP_BEQ, OP_BEQ, OP_BNE, OP_BNE, OP_J};
    bit         bz  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    bit         bex [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    function automatic bit is_r(input logic [4:0] op);
        return op inside {5'd0, 5'd1, 5'd4, 5'd6, 5'd7, 5'd17};
    endfunction
    function automatic bit is_i(input logic [4:0] op);
        return op inside {5'd2, 5'd3, 5'd5, 5'd8, 5'd9, 5'd10, 5'd11};
    endfunction
    function automatic bit writes(input logic [4:0] op);
        return is_r(op) || is_i(op) || op == OP_LDR;
    endfunction
    function automatic bit use1(input logic [4:0] op);
        return op <= 5'd17 && op != OP_J;
    endfunction
    function automatic bit use2(input logic [4:0] op);
        return is_r(op) || op inside {OP_STR, OP_BNE, OP_BEQ};
    endfunction
    function automatic bit hit(input rec_t s, input logic [3:0] src);
        return s.wr && s.rd != 4'd0 && s.rd == src;
    endfunction
`ifdef FWD_EN
    function automatic logic [1:0] fwd_of(input bit u, input logic [3:0] src);
        if (u && hit(pipe[0], src) && pipe[0].op != OP_LDR) return 2'd1;
        else if (u && hit(pipe[1], src)) return 2'd2;
        else return 2'd0;
    endfunction
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) passed = passed + 1;
        else begin
            failed = failed + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: present the ID instruction, check combinational outputs, clock, check stages.
    task automatic cycle(input logic [4:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] d, input bit z, input bit r);
        bit sel, stall, u1, u2;
        logic [1:0] fa, fb;
        bus.id_opcode = op; bus.id_rs1 = a; bus.id_rs2 = b; bus.id_rd = d;
        bus.ex_zero = z; rst = r;
        #1;
        u1  = use1(op);
        u2  = use2(op);
        sel = (pipe[0].op == OP_BEQ && z) || (pipe[0].op == OP_BNE && !z) || pipe[0].op == OP_J;
`ifdef FWD_EN
        stall = pipe[0].op == OP_LDR && ((u1 && hit(pipe[0], a)) || (u2 && hit(pipe[0], b)));
        fa = fwd_of(u1, a);
        fb = fwd_of(u2, b);
`else
        stall = 1'b0;
        for (int k = 0; k < 3; k++)
            if ((u1 && hit(pipe[k], a)) || (u2 && hit(pipe[k], b))) stall = 1'b1;
        fa = 2'd0;
        fb = 2'd0;
`endif
        if (sel) stall = 1'b0;
        if (comb_ok) begin
            chk("pc_select", bus.pc_select, sel);
            chk("flush_ifid", bus.flush_ifid, sel);
            chk("en_pc", bus.en_pc, !stall);
            chk("en_ifid", bus.en_ifid, !stall);
            chk("fwd_a", bus.fwd_a, fa);
            chk("fwd_b", bus.fwd_b, fb);
        end
        last_pcs = bus.pc_select; last_flush = bus.flush_ifid; last_en = bus.en_pc;
        last_fa = bus.fwd_a; last_fb = bus.fwd_b;
        @(posedge clk);
        #1;
        if (r) begin
            pipe[0] = BUB; pipe[1] = BUB; pipe[2] = BUB;
        end else begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (sel || stall) pipe[0] = BUB;
            else pipe[0] = '{op: op, wr: writes(op), rd: writes(op) ? d : 4'd0};
        end
        chk("ex_opcode", bus.ex_opcode, pipe[0].op);
        chk("ex_bsel", bus.ex_bsel, is_i(pipe[0].op) || pipe[0].op inside {OP_LDR, OP_STR});
        chk("mem_rd", bus.mem_rd, pipe[1].op == OP_LDR);
        chk("mem_wd", bus.mem_wd, pipe[1].op == OP_STR);
        chk("wb_reg_write", bus.wb_reg_write, pipe[2].wr);
        chk("wb_reg_sel", bus.wb_reg_sel,
            is_i(pipe[2].op) ? 2'd1 : (pipe[2].op == OP_LDR ? 2'd2 : 2'd0));
        chk("wb_rd", bus.wb_rd, pipe[2].rd);
        m_stall  = stall;
        m_branch = sel;
        comb_ok  = 1'b1;
    endtask

    task automatic drain();
        repeat (3) cycle(OP_NOP, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    endtask

    initial begin
        int edges;
        int stalls;
        logic [4:0] r_op;
        logic [3:0] r_a, r_b, r_d;
        int pick;
        pipe[0] = BUB; pipe[1] = BUB; pipe[2] = BUB;

        // Reset for two cycles: bubbles everywhere, enables high.
        cycle(OP_NOP, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
        cycle(OP_ADD, 4'd1, 4'd2, 4'd3, 1'b0, 1'b1);
        chk("rst_en_pc", bus.en_pc, 1'b1);
        chk("rst_en_ifid", bus.en_ifid, 1'b1);
        chk("rst_ex_opcode", bus.ex_opcode, 5'h1F);
        chk("rst_wb_write", bus.wb_reg_write, 1'b0);

        // ADDI r1 then ADD r2,r1,r1.
        drain();
        cycle(OP_ADDI, 4'd0, 4'd0, 4'd1, 1'b0, 1'b0);
        edges = 1;
        stalls = 0;
        for (int t = 0; t < 6; t++) begin
            cycle(OP_ADD, 4'd1, 4'd1, 4'd2, 1'b0, 1'b0);
            edges++;
            if (t == 0) begin
                chk("t2_fwd_a", last_fa, FWD ? 2'd1 : 2'd0);
                chk("t2_fwd_b", last_fb, FWD ? 2'd1 : 2'd0);
            end
            if (edges == 3) begin
                chk("t2_wb_write", bus.wb_reg_write, 1'b1);
                chk("t2_wb_sel", bus.wb_reg_sel, 2'd1);
                chk("t2_wb_rd", bus.wb_rd, 4'd1);
            end
            if (!m_stall) break;
            stalls++;
        end
        chk("t2_add_in_ex", bus.ex_opcode, OP_ADD);
        chk("t2_stalls", stalls, FWD ? 0 : 3);
        while (edges < 3) begin
            cycle(OP_NOP, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
            edges++;
            if (edges == 3) begin
                chk("t2_wb_write", bus.wb_reg_write, 1'b1);
                chk("t2_wb_sel", bus.wb_reg_sel, 2'd1);
                chk("t2_wb_rd", bus.wb_rd, 4'd1);
            end
        end

        // LDR r3 then ADD r4,r3,r0: load-use.
        drain();
        cycle(OP_LDR, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0);
        stalls = 0;
        for (int t = 0; t < 6; t++) begin
            cycle(OP_ADD, 4'd3, 4'd0, 4'd4, 1'b0, 1'b0);
            if (t == 0) begin
                chk("t3_en_pc", last_en, 1'b0);
                chk("t3_bubble", bus.ex_opcode, OP_NOP);
            end
            if (t == 1) chk("t3_fwd_a", last_fa, FWD ? 2'd2 : 2'd0);
            if (!m_stall) break;
            stalls++;
        end
        chk("t3_stalls", stalls, FWD ? 1 : 3);

        // Branch resolution table.
        drain();
        for (int k = 0; k < 5; k++) begin
            cycle(bop[k], 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
            cycle(OP_ADDI, 4'd0, 4'd0, 4'd6, bz[k], 1'b0);
            chk("t5_pc_select", last_pcs, bex[k]);
            chk("t5_flush", last_flush, bex[k]);
            chk("t5_ex_after", bus.ex_opcode, bex[k] ? OP_NOP : OP_ADDI);
            cycle(OP_NOP, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        end

        // Store, then store aborted by reset while in EX.
        drain();
        cycle(OP_STR, 4'd0, 4'd5, 4'd7, 1'b0, 1'b0);
        cycle(OP_NOP, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        chk("t6_mem_wd", bus.mem_wd, 1'b1);
        cycle(OP_NOP, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        chk("t6_wb_write", bus.wb_reg_write, 1'b0);
        cycle(OP_STR, 4'd0, 4'd5, 4'd0, 1'b0, 1'b0);
        cycle(OP_NOP, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
        chk("t6_rst_mem_wd", bus.mem_wd, 1'b0);
        cycle(OP_NOP, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        chk("t6_rst_mem_wd2", bus.mem_wd, 1'b0);

        // Random streams; ID holds on stall and becomes NOP after a flush.
        r_op = OP_NOP; r_a = 4'd0; r_b = 4'd0; r_d = 4'd0;
        for (int i = 0; i < 1500; i++) begin
            if (m_branch) begin
                r_op = OP_NOP; r_a = 4'd0; r_b = 4'd0; r_d = 4'd0;
            end else if (!m_stall) begin
                pick = $urandom_range(0, 23);
                r_op = pick <= 17 ? 5'(pick) : (pick <= 20 ? OP_NOP : 5'(pick + 5));
                r_a  = 4'($urandom_range(0, 7));
                r_b  = 4'($urandom_range(0, 7));
                r_d  = 4'($urandom_range(0, 7));
            end
            cycle(r_op, r_a, r_b, r_d, 1'($urandom_range(0, 1)), $urandom_range(0, 63) == 0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
